// File: rtl/datapath_pkg.sv
// Shared types and defaults for the processor datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datapath_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RF_AW  = 4;
    localparam int DEF_DM_AW  = 8;

    // ALU function codes as issued by the control unit
    typedef enum logic [2:0] {
        ALU_ZERO  = 3'd0,
        ALU_ADD   = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_PASSA = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_OR    = 3'd5,
        ALU_AND   = 3'd6,
        ALU_INC   = 3'd7
    } alu_op_t;

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with asynchronous clear.
// Latency: reads combinational; writes visible the cycle after the write edge.
// Backpressure: none; a write is accepted on every enabled edge.
module register_file #(
    parameter int DATA_W = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    input  logic              w_en,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    logic [DATA_W-1:0] regs [2**AW];

    // Write port; reset clears every entry and masks any write in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    // Read ports see the pre-edge contents, so read-during-write returns old data
    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
    end

endmodule

// File: rtl/processor_datapath.sv
// Executes control-unit words: register file, 8-op ALU, 256x16 data RAM, write-back mux.
// Latency: ALU/W_Data combinational; Mem_Q one cycle after D_Addr; RF/RAM writes on the edge.
// Backpressure: none; every control word is executed in the cycle it is presented.
module processor_datapath
    import datapath_pkg::*;
#(
    parameter int    DATA_W  = DEF_DATA_W,
    parameter int    RF_AW   = DEF_RF_AW,
    parameter int    DM_AW   = DEF_DM_AW,
    parameter string DM_INIT = ""
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic              D_Wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_Ra_Addr,
    input  logic [RF_AW-1:0]  RF_Rb_Addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_W_Addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [DATA_W-1:0] ALU_Out,
    output logic [DATA_W-1:0] Mem_Q,
    output logic [DATA_W-1:0] W_Data,
    output logic              Zero
);

    logic [DATA_W-1:0] dm [2**DM_AW];
    alu_op_t           alu_op;

    register_file #(
        .DATA_W (DATA_W),
        .AW     (RF_AW)
    ) u_rf (
        .clk     (Clock),
        .rst     (Reset),
        .ra_addr (RF_Ra_Addr),
        .rb_addr (RF_Rb_Addr),
        .w_en    (RF_W_en),
        .w_addr  (RF_W_Addr),
        .w_data  (W_Data),
        .ra_data (ALU_A),
        .rb_data (ALU_B)
    );

    assign alu_op = alu_op_t'(ALU_s0);

    // ALU: all results wrap modulo 2**DATA_W, no carry or overflow flags
    always_comb begin
        ALU_Out = '0;
        case (alu_op)
            ALU_ZERO:  ALU_Out = '0;
            ALU_ADD:   ALU_Out = ALU_A + ALU_B;
            ALU_SUB:   ALU_Out = ALU_A - ALU_B;
            ALU_PASSA: ALU_Out = ALU_A;
            ALU_XOR:   ALU_Out = ALU_A ^ ALU_B;
            ALU_OR:    ALU_Out = ALU_A | ALU_B;
            ALU_AND:   ALU_Out = ALU_A & ALU_B;
            ALU_INC:   ALU_Out = ALU_A + DATA_W'(1);
            default:   ALU_Out = '0;
        endcase
    end

    // Zero flag and write-back selection (1 = memory, 0 = ALU)
    always_comb begin
        Zero   = (ALU_Out == '0);
        W_Data = RF_s ? Mem_Q : ALU_Out;
    end

    // RAM store from the A side; contents survive reset but writes are held off during it
    always_ff @(posedge Clock) begin
        if (D_Wr && !Reset) begin
            dm[D_Addr] <= ALU_A;
        end
    end

    // Registered RAM read; read-during-write to the same word returns the old word
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Mem_Q <= '0;
        end else begin
            Mem_Q <= dm[D_Addr];
        end
    end

endmodule

// File: tb/tb_processor_datapath.sv
module tb_processor_datapath;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } sb_t;

    logic        Clock;
    logic        Reset;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic        RF_W_en;
    logic [3:0]  RF_W_Addr;
    logic [2:0]  ALU_s0;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [15:0] ALU_Out;
    logic [15:0] Mem_Q;
    logic [15:0] W_Data;
    logic        Zero;

    sb_t sb[$];
    sb_t e;
    int  n_checks = 0;
    int  n_fail   = 0;

    processor_datapath dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .RF_W_en    (RF_W_en),
        .RF_W_Addr  (RF_W_Addr),
        .ALU_s0     (ALU_s0),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_Out    (ALU_Out),
        .Mem_Q      (Mem_Q),
        .W_Data     (W_Data),
        .Zero       (Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One full cycle: through the rising edge, back to the falling edge
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Build a constant in register r by shift-and-add through the ALU
    task automatic load_const(input logic [3:0] r, input logic [15:0] v);
        RF_s = 1'b0; D_Wr = 1'b0;
        RF_Ra_Addr = r; RF_Rb_Addr = r; RF_W_Addr = r; RF_W_en = 1'b1;
        ALU_s0 = 3'd0;
        tick();
        for (int b = 15; b >= 0; b--) begin
            ALU_s0 = 3'd1;
            tick();
            if (v[b]) begin
                ALU_s0 = 3'd7;
                tick();
            end
        end
        RF_W_en = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        RF_s = 1'b0; D_Wr = 1'b0; D_Addr = 8'h00;
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd1; RF_W_Addr = 4'd1; RF_W_en = 1'b1;
        ALU_s0 = 3'd7;
        repeat (3) tick();
        sb.push_back('{tag: "pre_reset_r1", val: 16'h0003});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        // Reset mid-write: RF_W_en stays high throughout
        Reset = 1'b1;
        sb.push_back('{tag: "async_clear_r1", val: 16'h0000});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        tick();
        for (int i = 0; i < 16; i++) begin
            RF_Ra_Addr = 4'(i); RF_Rb_Addr = 4'(15 - i);
            sb.push_back('{tag: $sformatf("rst_ra%0d", i), val: 16'h0000});
            sb.push_back('{tag: $sformatf("rst_rb%0d", 15 - i), val: 16'h0000});
            #0.5;
            e = sb.pop_front(); n_checks++;
            if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
            e = sb.pop_front(); n_checks++;
            if (ALU_B !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_B, e.val); end
        end
        sb.push_back('{tag: "rst_mem_q", val: 16'h0000});
        e = sb.pop_front(); n_checks++;
        if (Mem_Q !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Mem_Q, e.val); end
        @(negedge Clock);
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd1;
        Reset = 1'b0;
        sb.push_back('{tag: "post_rst_before_edge", val: 16'h0000});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        tick();
        RF_W_en = 1'b0;
        sb.push_back('{tag: "first_write_after_rst", val: 16'h0001});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        @(negedge Clock);
    endtask

    task automatic test_alu_sweep();
        logic [15:0] exp_tbl [8];
        exp_tbl = '{16'h0000, 16'h000A, 16'h0004, 16'h0007,
                    16'h0004, 16'h0007, 16'h0003, 16'h0008};
        load_const(4'd1, 16'h0007);
        load_const(4'd2, 16'h0003);
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd2; RF_W_en = 1'b0;
        for (int op = 0; op < 8; op++) begin
            ALU_s0 = 3'(op);
            sb.push_back('{tag: $sformatf("alu_op%0d", op), val: exp_tbl[op]});
            #1;
            e = sb.pop_front(); n_checks++;
            if (ALU_Out !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_Out, e.val); end
        end
        sb.push_back('{tag: "zero_flag_op0", val: 16'h0001});
        ALU_s0 = 3'd0;
        #1;
        e = sb.pop_front(); n_checks++;
        if ({15'd0, Zero} !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Zero, e.val); end
        @(negedge Clock);
        // 0000 - 0001 wraps to FFFF; capture it in R7
        load_const(4'd6, 16'h0001);
        RF_Ra_Addr = 4'd0; RF_Rb_Addr = 4'd6; ALU_s0 = 3'd2;
        RF_W_Addr = 4'd7; RF_W_en = 1'b1;
        sb.push_back('{tag: "sub_wrap", val: 16'hFFFF});
        sb.push_back('{tag: "sub_wrap_zero", val: 16'h0000});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_Out !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_Out, e.val); end
        e = sb.pop_front(); n_checks++;
        if ({15'd0, Zero} !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Zero, e.val); end
        tick();
        RF_W_en = 1'b0; RF_Ra_Addr = 4'd7; ALU_s0 = 3'd7;
        sb.push_back('{tag: "inc_wrap", val: 16'h0000});
        sb.push_back('{tag: "inc_wrap_zero", val: 16'h0001});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_Out !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_Out, e.val); end
        e = sb.pop_front(); n_checks++;
        if ({15'd0, Zero} !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Zero, e.val); end
        @(negedge Clock);
    endtask

    task automatic test_store_load();
        load_const(4'd3, 16'h1234);
        RF_Ra_Addr = 4'd3; D_Addr = 8'h2A; D_Wr = 1'b1;
        tick();
        D_Wr = 1'b0;
        tick();
        sb.push_back('{tag: "load_mem_q", val: 16'h1234});
        #1;
        e = sb.pop_front(); n_checks++;
        if (Mem_Q !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Mem_Q, e.val); end
        RF_s = 1'b1; RF_W_en = 1'b1; RF_W_Addr = 4'd5; ALU_s0 = 3'd0;
        sb.push_back('{tag: "load_w_data", val: 16'h1234});
        #1;
        e = sb.pop_front(); n_checks++;
        if (W_Data !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, W_Data, e.val); end
        tick();
        RF_W_en = 1'b0; RF_s = 1'b0; RF_Ra_Addr = 4'd5;
        sb.push_back('{tag: "load_r5", val: 16'h1234});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        @(negedge Clock);
    endtask

    task automatic test_rf_read_during_write();
        load_const(4'd4, 16'h0011);
        load_const(4'd8, 16'h00FF);
        RF_Ra_Addr = 4'd4; RF_Rb_Addr = 4'd8; ALU_s0 = 3'd5;
        RF_s = 1'b0; RF_W_en = 1'b1; RF_W_Addr = 4'd4;
        sb.push_back('{tag: "rdw_old_a", val: 16'h0011});
        sb.push_back('{tag: "rdw_w_data", val: 16'h00FF});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        e = sb.pop_front(); n_checks++;
        if (W_Data !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, W_Data, e.val); end
        tick();
        RF_W_en = 1'b0;
        sb.push_back('{tag: "rdw_new_a", val: 16'h00FF});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        @(negedge Clock);
    endtask

    task automatic test_ram_read_during_write();
        load_const(4'd9, 16'hAAAA);
        load_const(4'd10, 16'h5555);
        RF_Ra_Addr = 4'd9; D_Addr = 8'h10; D_Wr = 1'b1;
        tick();
        RF_Ra_Addr = 4'd10;
        tick();
        D_Wr = 1'b0;
        sb.push_back('{tag: "ram_rdw_old", val: 16'hAAAA});
        #1;
        e = sb.pop_front(); n_checks++;
        if (Mem_Q !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Mem_Q, e.val); end
        tick();
        sb.push_back('{tag: "ram_rdw_new", val: 16'h5555});
        #1;
        e = sb.pop_front(); n_checks++;
        if (Mem_Q !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Mem_Q, e.val); end
        @(negedge Clock);
    endtask

    task automatic test_dual_write();
        // R1 = 0007, R2 = 0003 from the ALU sweep
        RF_Ra_Addr = 4'd1; RF_Rb_Addr = 4'd2; ALU_s0 = 3'd1; RF_s = 1'b0;
        RF_W_en = 1'b1; RF_W_Addr = 4'd11;
        D_Wr = 1'b1; D_Addr = 8'h20;
        tick();
        RF_W_en = 1'b0; D_Wr = 1'b0; RF_Ra_Addr = 4'd11;
        sb.push_back('{tag: "dual_rf", val: 16'h000A});
        #1;
        e = sb.pop_front(); n_checks++;
        if (ALU_A !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, ALU_A, e.val); end
        tick();
        sb.push_back('{tag: "dual_ram", val: 16'h0007});
        #1;
        e = sb.pop_front(); n_checks++;
        if (Mem_Q !== e.val) begin n_fail++; $display("FAIL %s got=%h exp=%h", e.tag, Mem_Q, e.val); end
        @(negedge Clock);
    endtask

    initial begin
        Reset = 1'b1;
        D_Addr = '0; D_Wr = 1'b0; RF_s = 1'b0;
        RF_Ra_Addr = '0; RF_Rb_Addr = '0; RF_W_en = 1'b0; RF_W_Addr = '0;
        ALU_s0 = '0;
        repeat (2) tick();
        test_reset();
        test_alu_sweep();
        test_store_load();
        test_rf_read_during_write();
        test_ram_read_during_write();
        test_dual_write();
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
